// File: rtl/motion_vec_sched_if.sv
// Tile-result handshake and overlay motion-memory write bus for motion_vec_sched.
// slave is the scheduler's view; master is the producer/overlay side.
interface motion_vec_sched_if #(
  parameter int SCORE_W = 16
) ();
  logic               res_valid;
  logic               res_ready;
  logic [7:0]         res_tile;
  logic [SCORE_W-1:0] res_score;
  logic               vec_we;
  logic [7:0]         vec_addr;
  logic               motion_detected;

  modport slave (
    input  res_valid, res_tile, res_score,
    output res_ready, vec_we, vec_addr, motion_detected
  );
  modport master (
    output res_valid, res_tile, res_score,
    input  res_ready, vec_we, vec_addr, motion_detected
  );
endinterface

// File: rtl/motion_vec_sched.sv
// Collects per-tile motion results during a frame, then on VSync rise sweeps all tiles
// out to the overlay memory. Optional per-tile motion persistence under MOTION_HOLD_EN.
module motion_vec_sched #(
  parameter int NTILES      = 256,
  parameter int SCORE_W     = 16,
  parameter int HOLD_FRAMES = 3
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               s_pVSync,
  input  logic               enable,
  input  logic [SCORE_W-1:0] thresh,
  motion_vec_sched_if.slave  bus,
  output logic               busy,
  output logic [8:0]         frame_motion_cnt,
  output logic               overrun
);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_e;

  localparam logic [7:0] LAST_ADDR = 8'(NTILES - 1);

  state_e            state_q;
  logic              vs_q;
  logic [NTILES-1:0] shadow_q;
  logic [7:0]        addr_q;
  logic [8:0]        cnt_q;
  logic              ready_q, we_q, md_q, busy_q, ovr_q;
  logic [7:0]        vaddr_q;
  logic [8:0]        fcnt_q;

  logic vs_rise, hit, last, flush_md;

  assign vs_rise = s_pVSync & ~vs_q;
  assign hit     = bus.res_valid & ready_q & (bus.res_score > thresh);
  assign last    = (addr_q == LAST_ADDR);

`ifdef MOTION_HOLD_EN
  localparam logic [1:0] HOLD_LD = 2'(HOLD_FRAMES);
  logic [NTILES-1:0][1:0] hold_q;
  // Held tiles report motion from the pre-update counter value.
  assign flush_md = shadow_q[addr_q] | (hold_q[addr_q] != 2'd0);
`else
  assign flush_md = shadow_q[addr_q];
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= IDLE;
      vs_q     <= 1'b0;
      shadow_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      vaddr_q  <= '0;
      md_q     <= 1'b0;
      busy_q   <= 1'b0;
      fcnt_q   <= '0;
      ovr_q    <= 1'b0;
`ifdef MOTION_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      vs_q   <= s_pVSync;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
          end
        end
        COLLECT: begin
          // A result accepted on the VSync edge still lands before the sweep.
          if (hit) shadow_q[bus.res_tile] <= 1'b1;
          if (vs_rise) begin
            state_q <= FLUSH;
            ready_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
          end else if (!enable) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          we_q             <= 1'b1;
          busy_q           <= 1'b1;
          vaddr_q          <= addr_q;
          md_q             <= flush_md;
          shadow_q[addr_q] <= 1'b0;
`ifdef MOTION_HOLD_EN
          if (shadow_q[addr_q])
            hold_q[addr_q] <= HOLD_LD;
          else if (hold_q[addr_q] != 2'd0)
            hold_q[addr_q] <= hold_q[addr_q] - 2'd1;
`endif
          if (vs_rise) ovr_q <= 1'b1;
          if (last) begin
            fcnt_q  <= cnt_q + 9'(flush_md);
            state_q <= enable ? COLLECT : IDLE;
            ready_q <= enable;
          end else begin
            addr_q <= addr_q + 8'd1;
            cnt_q  <= cnt_q + 9'(flush_md);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_ready       = ready_q;
  assign bus.vec_we          = we_q;
  assign bus.vec_addr        = vaddr_q;
  assign bus.motion_detected = md_q;
  assign busy                = busy_q;
  assign frame_motion_cnt    = fcnt_q;
  assign overrun             = ovr_q;
endmodule

// File: tb/tb_motion_vec_sched.sv
// Self-checking bench for motion_vec_sched: randomized results against a per-tile
// frame model; expectations follow MOTION_HOLD_EN when it is defined.
module tb_motion_vec_sched;
  localparam int NT = 256, SW = 16, HOLD = 3;

  logic          pclk = 1'b0, rst = 1'b1, s_pVSync = 1'b0, enable = 1'b0;
  logic [SW-1:0] thresh = '0;
  logic          busy, overrun;
  logic [8:0]    frame_motion_cnt;

  motion_vec_sched_if #(.SCORE_W(SW)) bus ();

  motion_vec_sched #(.NTILES(NT), .SCORE_W(SW), .HOLD_FRAMES(HOLD)) dut (
    .pclk(pclk), .rst(rst), .s_pVSync(s_pVSync), .enable(enable), .thresh(thresh),
    .bus(bus), .busy(busy), .frame_motion_cnt(frame_motion_cnt), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0;

  // Reference model: motion flag per tile for the current frame, plus persistence.
  bit  m_sh[NT];
  int  m_hold[NT];
  bit  exp_md[NT];
  int  exp_cnt;

  // Observations of one sweep, index k = cycles after the VSync-sampling edge.
  logic       o_we[NT+2], o_busy[NT+2], o_md[NT+2];
  logic [7:0] o_addr[NT+2];
  logic [8:0] o_cnt;
  logic       o_rdy;

  task automatic model_clear();
    for (int a = 0; a < NT; a++) begin m_sh[a] = 0; m_hold[a] = 0; end
  endtask

  task automatic model_flush();
    exp_cnt = 0;
    for (int a = 0; a < NT; a++) begin
`ifdef MOTION_HOLD_EN
      exp_md[a] = m_sh[a] || (m_hold[a] > 0);
      m_hold[a] = m_sh[a] ? HOLD : (m_hold[a] > 0 ? m_hold[a] - 1 : 0);
`else
      exp_md[a] = m_sh[a];
`endif
      m_sh[a] = 0;
      exp_cnt += int'(exp_md[a]);
    end
  endtask

  task automatic send_result(input int tile, input int score);
    int n = 0;
    @(negedge pclk);
    bus.res_valid = 1'b1; bus.res_tile = 8'(tile); bus.res_score = SW'(score);
    while (bus.res_ready !== 1'b1 && n < 20) begin @(negedge pclk); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout tile=%0d got res_ready=%b want 1", tile, bus.res_ready);
    end else begin
      @(posedge pclk);
      if (score > int'(thresh)) m_sh[tile] = 1;
      @(negedge pclk);
    end
    bus.res_valid = 1'b0;
  endtask

  task automatic run_sweep(input int ovr_at, input int drop_at);
    @(negedge pclk); s_pVSync = 1'b1;
    @(negedge pclk); s_pVSync = 1'b0;
    o_we[0] = bus.vec_we; o_busy[0] = busy; o_md[0] = bus.motion_detected; o_addr[0] = bus.vec_addr;
    for (int k = 1; k < NT + 2; k++) begin
      @(negedge pclk);
      s_pVSync = (k == ovr_at);
      if (k == drop_at) enable = 1'b0;
      o_we[k] = bus.vec_we; o_busy[k] = busy; o_md[k] = bus.motion_detected; o_addr[k] = bus.vec_addr;
    end
    s_pVSync = 1'b0;
    o_cnt = frame_motion_cnt;
    o_rdy = bus.res_ready;
    model_flush();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    bus.res_valid = 1'b0; bus.res_tile = '0; bus.res_score = '0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({bus.res_ready, bus.vec_we, bus.vec_addr, bus.motion_detected, busy, frame_motion_cnt, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b addr=%0d md=%b busy=%b cnt=%0d ovr=%b want all 0",
               bus.res_ready, bus.vec_we, bus.vec_addr, bus.motion_detected, busy, frame_motion_cnt, overrun);
    end
    model_clear();
    rst = 1'b0; enable = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus.res_ready !== 1'b1) begin
      errors++; $display("FAIL collect_ready got %b want 1", bus.res_ready);
    end
  endtask

  task automatic test_thresh_latency();
    thresh = 16'd100;
    send_result(8'h25, 101);
    send_result(8'h26, 100);
    run_sweep(0, 0);
    for (int k = 0; k < NT + 2; k++) begin
      logic ew;
      ew = (k >= 1 && k <= NT);
      checks++;
      if (o_we[k] !== ew || o_busy[k] !== ew) begin
        errors++; $display("FAIL sweep_timing k=%0d got we=%b busy=%b want %b", k, o_we[k], o_busy[k], ew);
      end
      if (ew) begin
        checks++;
        if (o_addr[k] !== 8'(k - 1) || o_md[k] !== exp_md[k-1]) begin
          errors++;
          $display("FAIL sweep_data k=%0d got addr=%0d md=%b want addr=%0d md=%b", k, o_addr[k], o_md[k], k - 1, exp_md[k-1]);
        end
      end
    end
    checks++;
    if (o_md[8'h25 + 1] !== 1'b1 || o_md[8'h26 + 1] !== 1'b0) begin
      errors++; $display("FAIL thresh_strict got md25=%b md26=%b want 1 0", o_md[8'h25 + 1], o_md[8'h26 + 1]);
    end
    checks++;
    if (o_cnt !== 9'd1) begin errors++; $display("FAIL frame_cnt_first got %0d want 1", o_cnt); end
  endtask

  task automatic test_or_repeat();
    int nsw;
    bit want;
`ifdef MOTION_HOLD_EN
    nsw = HOLD + 2;
`else
    nsw = 2;
`endif
    thresh = 16'd100;
    send_result(8'h10, 200);
    send_result(8'h10, 5);
    for (int s = 0; s < nsw; s++) begin
      if (s > 0) run_sweep(0, 0); else run_sweep(0, 0);
      want = (s < nsw - 1);
      checks++;
      if (o_md[8'h10 + 1] !== want) begin
        errors++; $display("FAIL or_hold sweep=%0d got md=%b want %b", s, o_md[8'h10 + 1], want);
      end
      checks++;
      if (o_cnt !== 9'(exp_cnt)) begin
        errors++; $display("FAIL or_hold_cnt sweep=%0d got %0d want %0d", s, o_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_idle();
    bit seen = 0;
    thresh = 16'd50;
    send_result(8'h40, 300);
    @(negedge pclk); enable = 1'b0;
    @(negedge pclk);
    checks++;
    if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", bus.res_ready); end
    s_pVSync = 1'b1;
    repeat (3) @(negedge pclk);
    s_pVSync = 1'b0;
    repeat (20) begin @(negedge pclk); if (bus.vec_we !== 1'b0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL idle_vsync got vec_we=1 want 0"); end
    enable = 1'b1;
    repeat (2) @(negedge pclk);
    run_sweep(0, 0);
    checks++;
    if (o_md[8'h40 + 1] !== 1'b1 || o_md[8'h40 + 1] !== exp_md[8'h40]) begin
      errors++; $display("FAIL idle_retain got md=%b want 1", o_md[8'h40 + 1]);
    end
  endtask

  task automatic test_overrun_enable_drop();
    int nwe = 0;
    bit gap = 0, extra = 0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got %b want 0", overrun); end
    send_result(8'h80, 1000);
    run_sweep(10, 50);
    for (int k = 1; k <= NT; k++) begin
      if (o_we[k] === 1'b1) nwe++;
      if (o_we[k] !== 1'b1 || o_addr[k] !== 8'(k - 1)) gap = 1;
    end
    checks++;
    if (gap || nwe != NT || o_we[NT+1] !== 1'b0) begin
      errors++; $display("FAIL overrun_sweep got writes=%0d gap=%b want %0d 0", nwe, gap, NT);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++;
    if (o_md[8'h80 + 1] !== exp_md[8'h80] || o_cnt !== 9'(exp_cnt)) begin
      errors++; $display("FAIL overrun_data got md=%b cnt=%0d want %b %0d", o_md[8'h80 + 1], o_cnt, exp_md[8'h80], exp_cnt);
    end
    checks++;
    if (o_rdy !== 1'b0) begin errors++; $display("FAIL drop_to_idle got res_ready=%b want 0", o_rdy); end
    repeat (30) begin @(negedge pclk); if (bus.vec_we !== 1'b0) extra = 1; end
    checks++;
    if (extra || overrun !== 1'b1) begin
      errors++; $display("FAIL single_sweep got extra_we=%b overrun=%b want 0 1", extra, overrun);
    end
    enable = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int bad = 0;
      thresh = SW'($urandom_range(0, 300));
      repeat (40) send_result($urandom_range(0, NT - 1), $urandom_range(0, 400));
      run_sweep(0, 0);
      for (int a = 0; a < NT; a++) begin
        checks++;
        if (o_md[a+1] !== exp_md[a]) begin
          errors++; bad++;
          if (bad < 8) $display("FAIL rand_md frame=%0d tile=%0d got %b want %b", f, a, o_md[a+1], exp_md[a]);
        end
      end
      checks++;
      if (o_cnt !== 9'(exp_cnt)) begin
        errors++; $display("FAIL rand_cnt frame=%0d got %0d want %0d", f, o_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid_sweep();
    int n = 0;
    bit nz = 0;
    thresh = 16'd10;
    repeat (8) send_result($urandom_range(0, NT - 1), 500);
    send_result(150, 500);
    @(negedge pclk); s_pVSync = 1'b1;
    @(negedge pclk); s_pVSync = 1'b0;
    while (!(bus.vec_we === 1'b1 && bus.vec_addr === 8'd100) && n < 400) begin @(negedge pclk); n++; end
    checks++;
    if (n == 400) begin
      errors++; $display("FAIL rst_mid_wait got no addr 100 want vec_addr=100");
    end
    rst = 1'b1;
    @(negedge pclk);
    checks++;
    if ({bus.vec_we, bus.vec_addr, bus.motion_detected, busy, frame_motion_cnt, overrun, bus.res_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got we=%b addr=%0d md=%b busy=%b cnt=%0d ovr=%b rdy=%b want all 0",
               bus.vec_we, bus.vec_addr, bus.motion_detected, busy, frame_motion_cnt, overrun, bus.res_ready);
    end
    model_clear();
    rst = 1'b0; enable = 1'b1;
    repeat (2) @(negedge pclk);
    run_sweep(0, 0);
    for (int a = 0; a < NT; a++) if (o_md[a+1] !== 1'b0) nz = 1;
    checks++;
    if (nz || o_cnt !== 9'd0 || exp_cnt != 0) begin
      errors++; $display("FAIL rst_clears_shadow got nonzero=%b cnt=%0d want 0 0", nz, o_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_thresh_latency();
    test_or_repeat();
    test_idle();
    test_overrun_enable_drop();
    test_random();
    test_rst_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
